kbd_spi_tx: RTL and testbench
=============================

Name: kbd_spi_tx

Overview:
- SPI master that serialises the ZX keyboard matrix and PS/2 special keys (MAGIC, TURBO, PNT).
- Drives the KBD_CS / KBD_CLK / KBD_DI lines that the main Pentagon CPLD receives.
- Lives in the PS/2-controller side logic, or in a test fixture that emulates that controller.
- Free-running frames with a fixed header and parity, so the receiver can resynchronise on every frame.

Parameters:
- CLK_DIV, 7: CLK_14MHZ cycles per SCK half-period (7 gives 1 MHz SCK); legal range 2..255.
- GAP_TICKS, 16: half-period ticks with KBD_CS high between frames; legal range 1..255.

Ports:
- CLK_14MHZ  in  1  main 14 MHz clock; the only clock.
- RESET_n  in  1  asynchronous active-low reset.
- EN  in  1  frame enable; sampled only in IDLE.
- KEYS  in  40  matrix snapshot source, active low (0 = pressed); [39:35] row A15 … [4:0] row A8, bit 0 of each row = D0 column; synchronous to CLK_14MHZ.
- MAGIC  in  1  magic key, active high.
- TURBO  in  1  turbo key, active high.
- PNT  in  1  PrintScreen key, active high.
- KBD_CS  out  1  frame select, active low.
- KBD_CLK  out  1  SCK; idles low (SPI mode 0).
- KBD_DI  out  1  serial data; MSB first.
- BUSY  out  1  high while KBD_CS is low.
- FRAME_DONE  out  1  one-cycle pulse when KBD_CS rises.

Behaviour:
- Reset (async, RESET_n=0):
  - KBD_CS=1, KBD_CLK=0, KBD_DI=1, BUSY=0, FRAME_DONE=0.
  - state=IDLE, all counters 0.
  - Release is synchronous to CLK_14MHZ.
- Tick generator:
  - Divider counts 0..CLK_DIV-1 and wraps.
  - tick is high for the one cycle at terminal count.
  - Divider free-runs in every state.
- Frame, 56 bits, sent MSB first:
  - [55:48] = 8'hA5.
  - [47:8] = KEYS.
  - [7:5] = {MAGIC, TURBO, PNT}.
  - [4:1] = 4'b0000.
  - [0] = parity, chosen so the XOR of bits [47:0] is 0 (even parity over payload).
- Snapshot:
  - All payload inputs are captured into the 56-bit shift register on the cycle of IDLE→SHIFT.
  - Input changes during a frame never alter it.
- IDLE:
  - Outputs held at their idle values.
  - Gap counter increments on each tick.
  - When the count reaches GAP_TICKS on a tick and EN=1: load snapshot, KBD_CS←0, KBD_DI←frame[55], bit_cnt←55, BUSY←1, go to SHIFT.
  - If EN=0 at that point, the gap counter saturates and the load happens on the first tick with EN=1.
- SHIFT (each tick toggles KBD_CLK):
  - 0→1 (rising): data held; the receiver samples here.
  - 1→0 (falling), bit_cnt≠0: shift left, KBD_DI←next bit, bit_cnt−1.
  - 1→0 (falling), bit_cnt=0: KBD_CLK←0, go to HOLD.
- HOLD:
  - Lasts one tick.
  - Then KBD_CS←1, KBD_DI←1, BUSY←0, FRAME_DONE=1 for one cycle.
  - Gap counter cleared, go to IDLE.
- Timing at defaults:
  - KBD_CS fall to first KBD_CLK rise = CLK_DIV cycles (7).
  - KBD_CS low for 113×CLK_DIV cycles (791).
  - KBD_CS high between frames = GAP_TICKS×CLK_DIV cycles (112).
  - Exactly 56 rising edges per frame.
- EN deasserted mid-frame: the current frame completes; no further frame starts.
- Reset mid-frame: frame aborted immediately with idle outputs; the next frame starts after a full gap.
- Outputs are registered; no combinational path from inputs to pins.

Decomposition:
- Shared package kbd_spi_pkg holds:
  - HDR = 8'hA5, FRAME_BITS = 56;
  - field offsets KEYS_MSB=47, CTRL_MSB=7;
  - state enum {IDLE, SHIFT, HOLD}.
- The same package is imported by the CPLD-side receiver.
- One sub-module, kbd_spi_tick: the CLK_DIV divider producing the tick strobe.

Test Plan:
1. Reset, KEYS all 1, EN=1, no special keys, defaults. Required response:
   - First KBD_CS fall at 112 cycles after reset release.
   - Receiver model captures 0xA5, then 0xFF_FFFF_FFFF, then ctrl 0x00, then parity 0.
   - KBD_CS low for 791 cycles; FRAME_DONE pulse 1 cycle wide.
2. KEYS = 40'hFF_FFFF_FFFE (CAPS pressed), MAGIC=1. Required response:
   - Payload [47:8] matches KEYS; bits [7:5] = 3'b100.
   - Parity bit = 0 (payload XOR is 0).
   - A single pressed key with no special keys instead gives parity 1.
3. Toggle KEYS every 50 cycles during a frame. Required response: each received frame equals the value present on the IDLE→SHIFT cycle.
4. EN←0 at bit 20 of a frame. Required response:
   - The frame completes with 56 rising edges.
   - KBD_CS stays high for 5000 cycles.
   - EN←1: next frame starts on the next tick.
5. RESET_n pulsed low at bit 30. Required response:
   - KBD_CS=1, KBD_CLK=0, KBD_DI=1 asynchronously, before the next clock edge.
   - Next frame is complete and correct after the full gap.
6. CLK_DIV=2, GAP_TICKS=1. Required response:
   - SCK period = 4 cycles.
   - Gap = 2 cycles.
   - Frames back-to-back with no lost or extra bits over 10 frames.

Source files
------------

// File: rtl/kbd_spi_pkg.sv
// Shared definitions for the ZX keyboard SPI link; imported by both transmitter and CPLD receiver.
// Frame layout, MSB first: HDR[55:48] | KEYS[47:8] | {MAGIC,TURBO,PNT}[7:5] | 0000[4:1] | parity[0].
package kbd_spi_pkg;
  localparam logic [7:0] HDR        = 8'hA5;
  localparam int         FRAME_BITS = 56;
  localparam int         KEYS_MSB   = 47;
  localparam int         CTRL_MSB   = 7;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} kbd_state_e;

  // Parity bit makes the XOR of the whole 48-bit payload zero.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [39:0] keys,
                                                        input logic [2:0]  ctrl);
    logic [KEYS_MSB:0] payload;
    payload                 = '0;
    payload[KEYS_MSB -: 40] = keys;
    payload[CTRL_MSB -: 3]  = ctrl;
    return {HDR, payload[KEYS_MSB:1], ^payload};
  endfunction
endpackage

// File: rtl/kbd_spi_tx_if.sv
// Keyboard snapshot inputs and SPI pin bundle; master = PS/2-side transmitter, slave = its environment.
// Pure wiring, no latency; the link has no backpressure.
interface kbd_spi_tx_if;
  logic        EN;
  logic [39:0] KEYS;
  logic        MAGIC;
  logic        TURBO;
  logic        PNT;
  logic        KBD_CS;
  logic        KBD_CLK;
  logic        KBD_DI;
  logic        BUSY;
  logic        FRAME_DONE;

  modport master (
    input  EN, KEYS, MAGIC, TURBO, PNT,
    output KBD_CS, KBD_CLK, KBD_DI, BUSY, FRAME_DONE
  );

  modport slave (
    output EN, KEYS, MAGIC, TURBO, PNT,
    input  KBD_CS, KBD_CLK, KBD_DI, BUSY, FRAME_DONE
  );
endinterface

// File: rtl/kbd_spi_tick.sv
// Free-running divider: one-cycle tick every CLK_DIV clocks (SCK half-period strobe).
// Latency: first tick CLK_DIV-1 cycles after reset release; no backpressure, never stops.
module kbd_spi_tick #(
  parameter int CLK_DIV = 7
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  logic [7:0] cnt;

  assign tick = (cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (tick) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: rtl/kbd_spi_tx.sv
// SPI mode-0 master streaming 56-bit keyboard frames, snapshot taken on the IDLE->SHIFT cycle.
// Latency: frame starts GAP_TICKS*CLK_DIV cycles after KBD_CS rises; no backpressure, EN only gates frame starts.
module kbd_spi_tx
  import kbd_spi_pkg::*;
#(
  parameter int CLK_DIV   = 7,
  parameter int GAP_TICKS = 16
) (
  input  logic         CLK_14MHZ,
  input  logic         RESET_n,
  kbd_spi_tx_if.master kbd
);
  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_SHIFT = 2'(SHIFT);
  localparam logic [1:0] ST_HOLD  = 2'(HOLD);

  logic                  tick;
  logic [1:0]            state;
  logic [7:0]            gap_cnt;
  logic [5:0]            bit_cnt;
  logic [FRAME_BITS-2:0] shreg;
  logic [FRAME_BITS-1:0] snap;
  logic                  gap_done;
  logic                  cs_q;
  logic                  sck_q;
  logic                  di_q;
  logic                  busy_q;
  logic                  done_q;

  kbd_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (CLK_14MHZ),
    .rst_n (RESET_n),
    .tick  (tick)
  );

  assign snap     = build_frame(kbd.KEYS, {kbd.MAGIC, kbd.TURBO, kbd.PNT});
  // True on the tick that brings the gap count to GAP_TICKS (or beyond, once saturated).
  assign gap_done = ({1'b0, gap_cnt} + 9'd1) >= 9'(GAP_TICKS);

  always_ff @(posedge CLK_14MHZ or negedge RESET_n) begin
    if (!RESET_n) begin
      state   <= ST_IDLE;
      gap_cnt <= 8'd0;
      bit_cnt <= 6'd0;
      shreg   <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      di_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (gap_done && kbd.EN) begin
              shreg   <= snap[FRAME_BITS-2:0];
              di_q    <= snap[FRAME_BITS-1];
              bit_cnt <= 6'(FRAME_BITS - 1);
              cs_q    <= 1'b0;
              busy_q  <= 1'b1;
              state   <= ST_SHIFT;
            end else if (gap_cnt != 8'(GAP_TICKS)) begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
          ST_SHIFT: begin
            if (!sck_q) begin
              sck_q <= 1'b1;
            end else if (bit_cnt != 6'd0) begin
              sck_q   <= 1'b0;
              di_q    <= shreg[FRAME_BITS-2];
              shreg   <= {shreg[FRAME_BITS-3:0], 1'b0};
              bit_cnt <= bit_cnt - 6'd1;
            end else begin
              sck_q <= 1'b0;
              state <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            cs_q    <= 1'b1;
            di_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            gap_cnt <= 8'd0;
            state   <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign kbd.KBD_CS     = cs_q;
  assign kbd.KBD_CLK    = sck_q;
  assign kbd.KBD_DI     = di_q;
  assign kbd.BUSY       = busy_q;
  assign kbd.FRAME_DONE = done_q;
endmodule

// File: tb/tb_kbd_spi_tx.sv
// Bench for kbd_spi_tx: default-parameter DUT plus a CLK_DIV=2/GAP_TICKS=1 DUT, each watched by a receiver model.
// Expected frames are queued at each KBD_CS fall from the inputs the bench drove on that clock edge.
module tb_kbd_spi_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst1_n;
  logic        en0, en1, m0, t0, p0, m1, t1, p1;
  logic [39:0] keys0, keys1;

  kbd_spi_tx_if if0 ();
  kbd_spi_tx_if if1 ();
  assign if0.EN = en0;  assign if0.KEYS = keys0;
  assign if0.MAGIC = m0; assign if0.TURBO = t0; assign if0.PNT = p0;
  assign if1.EN = en1;  assign if1.KEYS = keys1;
  assign if1.MAGIC = m1; assign if1.TURBO = t1; assign if1.PNT = p1;

  kbd_spi_tx u_dut0 (.CLK_14MHZ(clk), .RESET_n(rst0_n), .kbd(if0));
  kbd_spi_tx #(.CLK_DIV(2), .GAP_TICKS(1)) u_dut1 (.CLK_14MHZ(clk), .RESET_n(rst1_n), .kbd(if1));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Inputs as seen by the DUTs on the most recent clock edge.
  logic [42:0] snap0, snap1;
  always @(posedge clk) begin
    snap0 <= {keys0, m0, t0, p0};
    snap1 <= {keys1, m1, t1, p1};
  end

  function automatic logic [55:0] exp_frame(input logic [42:0] s);
    return {8'hA5, s[42:3], s[2:0], 4'b0000, ^s};
  endfunction

  logic [55:0] q0[$];
  logic [55:0] q1[$];

  int          fall_cyc[2], rise_cyc[2], last_sck[2], rises[2], done_cnt[2], per_bad[2], busy_bad[2];
  logic        prev_cs[2], prev_sck[2], in_frame[2], fd_low_next[2], chk_gap[2];
  logic [55:0] rx[2], last_rx[2];

  function automatic string tg(input int d, input string s);
    return $sformatf("d%0d_%s", d, s);
  endfunction

  task automatic mon_step(input int d, input logic rst, input logic cs, input logic sck,
                          input logic di, input logic busy, input logic fd, input logic [42:0] sn);
    int          div;
    int          gapt;
    logic [55:0] e;
    div  = (d == 0) ? 7 : 2;
    gapt = (d == 0) ? 16 : 1;
    if (!rst) begin
      in_frame[d] = 1'b0; prev_cs[d] = 1'b1; prev_sck[d] = 1'b0; fd_low_next[d] = 1'b0;
      if (d == 0) q0.delete(); else q1.delete();
      return;
    end
    if (fd_low_next[d]) begin
      chk_eq(tg(d, "frame_done_width"), fd, 0);
      fd_low_next[d] = 1'b0;
    end
    if (busy !== ~cs) busy_bad[d]++;
    if (prev_cs[d] && !cs) begin
      if (chk_gap[d]) chk_eq(tg(d, "gap_len"), cyc - rise_cyc[d], gapt * div);
      fall_cyc[d] = cyc; in_frame[d] = 1'b1; rises[d] = 0; per_bad[d] = 0; rx[d] = '0;
      if (d == 0) q0.push_back(exp_frame(sn)); else q1.push_back(exp_frame(sn));
    end
    if (in_frame[d] && !cs && !prev_sck[d] && sck) begin
      if (rises[d] == 0) chk_eq(tg(d, "cs_to_first_sck"), cyc - fall_cyc[d], div);
      else if (cyc - last_sck[d] != 2 * div) per_bad[d]++;
      last_sck[d] = cyc;
      rx[d] = {rx[d][54:0], di};
      rises[d]++;
    end
    if (in_frame[d] && !prev_cs[d] && cs) begin
      chk_eq(tg(d, "cs_low_len"), cyc - fall_cyc[d], 113 * div);
      chk_eq(tg(d, "sck_rises"), rises[d], 56);
      chk_eq(tg(d, "sck_period_errs"), per_bad[d], 0);
      chk_eq(tg(d, "busy_errs"), busy_bad[d], 0);
      chk_eq(tg(d, "frame_done_pulse"), fd, 1);
      chk_eq(tg(d, "sb_has_entry"), (d == 0) ? (q0.size() != 0) : (q1.size() != 0), 1);
      if (d == 0 && q0.size() != 0) begin e = q0.pop_front(); chk_eq(tg(d, "frame"), rx[d], e); end
      if (d == 1 && q1.size() != 0) begin e = q1.pop_front(); chk_eq(tg(d, "frame"), rx[d], e); end
      fd_low_next[d] = 1'b1; busy_bad[d] = 0;
      last_rx[d] = rx[d]; done_cnt[d]++; rise_cyc[d] = cyc; in_frame[d] = 1'b0;
    end
    prev_cs[d]  = cs;
    prev_sck[d] = sck;
  endtask

  always @(negedge clk) begin
    mon_step(0, rst0_n, if0.KBD_CS, if0.KBD_CLK, if0.KBD_DI, if0.BUSY, if0.FRAME_DONE, snap0);
    mon_step(1, rst1_n, if1.KBD_CS, if1.KBD_CLK, if1.KBD_DI, if1.BUSY, if1.FRAME_DONE, snap1);
  end

  task automatic wait_done(input int d, input int n, input int budget, input string tag);
    int target;
    target = done_cnt[d] + n;
    for (int c = 0; c < budget && done_cnt[d] < target; c++) @(negedge clk);
    chk_eq(tag, done_cnt[d], target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_en, dl, bad;
    for (int d = 0; d < 2; d++) begin
      done_cnt[d] = 0; rises[d] = 0; busy_bad[d] = 0; per_bad[d] = 0; in_frame[d] = 1'b0;
      prev_cs[d] = 1'b1; prev_sck[d] = 1'b0; fd_low_next[d] = 1'b0; rise_cyc[d] = 0;
      fall_cyc[d] = 0; last_sck[d] = 0; rx[d] = '0; last_rx[d] = '0;
    end
    chk_gap[0] = 1'b1; chk_gap[1] = 1'b0;
    rst0_n = 1'b0; rst1_n = 1'b0;
    en0 = 1'b1; keys0 = '1; m0 = 1'b0; t0 = 1'b0; p0 = 1'b0;
    en1 = 1'b0; keys1 = '1; m1 = 1'b0; t1 = 1'b0; p1 = 1'b0;

    repeat (3) @(negedge clk);
    chk_eq("rst_cs",   {if0.KBD_CS, if1.KBD_CS}, 2'b11);
    chk_eq("rst_clk",  {if0.KBD_CLK, if1.KBD_CLK}, 2'b00);
    chk_eq("rst_di",   {if0.KBD_DI, if1.KBD_DI}, 2'b11);
    chk_eq("rst_busy", {if0.BUSY, if1.BUSY}, 2'b00);
    chk_eq("rst_done", {if0.FRAME_DONE, if1.FRAME_DONE}, 2'b00);
    rst0_n = 1'b1; rst1_n = 1'b1; rise_cyc[0] = cyc;

    // 1: idle keyboard; first fall 112 cycles after release is covered by the gap check.
    wait_done(0, 1, 1500, "t1_frame_seen");
    chk_eq("t1_hdr",    last_rx[0][55:48], 8'hA5);
    chk_eq("t1_keys",   last_rx[0][47:8], 40'hFF_FFFF_FFFF);
    chk_eq("t1_ctrl",   last_rx[0][7:1], 7'h00);
    chk_eq("t1_parity", last_rx[0][0], 1'b0);

    // 2: CAPS + MAGIC gives even payload; CAPS alone needs parity 1.
    keys0 = 40'hFF_FFFF_FFFE; m0 = 1'b1;
    wait_done(0, 2, 2500, "t2a_frames");
    chk_eq("t2a_frame",  last_rx[0], 56'hA5_FF_FFFF_FFFE_80);
    chk_eq("t2a_parity", last_rx[0][0], 1'b0);
    m0 = 1'b0;
    wait_done(0, 2, 2500, "t2b_frames");
    chk_eq("t2b_frame",  last_rx[0], 56'hA5_FF_FFFF_FFFE_01);
    chk_eq("t2b_parity", last_rx[0][0], 1'b1);

    // 3: inputs churn every 50 cycles; the scoreboard holds each frame to its load-edge snapshot.
    t_en = done_cnt[0];
    for (int i = 0; i < 60; i++) begin
      repeat (50) @(negedge clk);
      keys0 = {8'($urandom), 32'($urandom)};
      {m0, t0, p0} = 3'($urandom);
    end
    chk_eq("t3_enough_frames", done_cnt[0] - t_en >= 3, 1);
    keys0 = '1; {m0, t0, p0} = 3'b000;

    // 4: drop EN mid-frame, expect a clean finish and silence, then a prompt restart.
    for (int c = 0; c < 1200 && !(in_frame[0] && rises[0] >= 20); c++) @(negedge clk);
    chk_eq("t4_reached_bit20", in_frame[0] && rises[0] >= 20, 1);
    en0 = 1'b0; chk_gap[0] = 1'b0;
    wait_done(0, 1, 1000, "t4_frame_completes");
    bad = 0;
    repeat (5000) begin
      @(negedge clk);
      if (if0.KBD_CS !== 1'b1) bad++;
    end
    chk_eq("t4_cs_high_5000", bad, 0);
    @(negedge clk);
    en0 = 1'b1; t_en = cyc;
    for (int c = 0; c < 20 && if0.KBD_CS !== 1'b0; c++) @(negedge clk);
    dl = cyc - t_en;
    chk_eq("t4_restart_within_tick", dl >= 1 && dl <= 7, 1);
    wait_done(0, 1, 1000, "t4_restart_frame");
    chk_gap[0] = 1'b1;

    // 5: asynchronous reset mid-frame.
    for (int c = 0; c < 2000 && !(in_frame[0] && rises[0] >= 30); c++) @(negedge clk);
    chk_eq("t5_reached_bit30", in_frame[0] && rises[0] >= 30, 1);
    #1 rst0_n = 1'b0;
    #1;
    chk_eq("t5_async_cs",   if0.KBD_CS, 1'b1);
    chk_eq("t5_async_clk",  if0.KBD_CLK, 1'b0);
    chk_eq("t5_async_di",   if0.KBD_DI, 1'b1);
    chk_eq("t5_async_busy", if0.BUSY, 1'b0);
    repeat (3) @(negedge clk);
    rst0_n = 1'b1; rise_cyc[0] = cyc;
    wait_done(0, 2, 2500, "t5_frames_after_reset");
    chk_eq("t5_frame", last_rx[0], 56'hA5_FF_FFFF_FFFF_00);

    // 6: fastest settings, back-to-back frames with changing keys.
    en1 = 1'b1;
    wait_done(1, 1, 400, "t6_first_frame");
    chk_gap[1] = 1'b1;
    t_en = done_cnt[1] + 10;
    for (int c = 0; c < 3000 && done_cnt[1] < t_en; c++) begin
      @(negedge clk);
      if (c % 37 == 0) begin
        keys1 = {8'($urandom), 32'($urandom)};
        {m1, t1, p1} = 3'($urandom);
      end
    end
    chk_eq("t6_ten_frames", done_cnt[1], t_en);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
